// File: rtl/acia_fifo_pkg.sv
// acia_fifo_uart shared definitions: register map, bit positions,
// frame state encodings and oversampling constant.
package acia_fifo_pkg;

  localparam logic [1:0] REG_STAT_CTL = 2'd0;
  localparam logic [1:0] REG_DATA     = 2'd1;
  localparam logic [1:0] REG_DIV_LO   = 2'd2;
  localparam logic [1:0] REG_DIV_HI   = 2'd3;

  localparam int BIT_RDRF = 0;
  localparam int BIT_TDRE = 1;
  localparam int BIT_FE   = 4;
  localparam int BIT_OVRN = 5;
  localparam int BIT_LOOP = 6;
  localparam int BIT_IRQ  = 7;
  localparam int BIT_TXIE = 5;
  localparam int BIT_RXIE = 7;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/acia_fifo_uart_if.sv
// acia_fifo_uart CPU bus bundle: strobe, direction, select,
// data both ways and the interrupt line.
interface acia_fifo_uart_if;
  logic       cs;
  logic       rw;
  logic [1:0] rs;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  modport master (
    output cs, rw, rs, data_in,
    input  data_out, irq
  );

  modport slave (
    input  cs, rw, rs, data_in,
    output data_out, irq
  );
endinterface

// File: rtl/acia_fifo_uart_sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers and a
// synchronous flush; head is visible combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // pointer advance; push and pop in one cycle both move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  // storage write, no reset needed on the array
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/acia_fifo_uart.sv
// acia_fifo_uart: 6850-style UART with 16x baud generator and FIFOs.
// Define ACIA_FIFO_UART_LOOPBACK_EN for the internal TX->RX loopback.
module acia_fifo_uart
  import acia_fifo_pkg::*;
#(
  parameter int                   FIFO_DEPTH  = 16,
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 'h1A
) (
  input  logic              clk,
  input  logic              rst,
  acia_fifo_uart_if.slave   bus,
  input  logic              rx,
  output logic              tx
);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] HALF = 4'(OVERSAMPLE / 2 - 1);

  logic wr_acc, rd_acc, ctl_wr, mrst, stat_rd, data_rd;
  logic [DIV_WIDTH-1:0] div, div_nxt, cnt;
  logic div_wr, tick;
  logic [15:0] div_ext;
  logic rxie, txie, fe, ovrn, irq_q;
  logic loop_en;
  logic tx_full, tx_empty, tx_pop, tx_q;
  logic [7:0] tx_rdata, tx_shift;
  tx_state_t tx_state;
  logic [3:0] tx_cnt;
  logic [2:0] tx_bit;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_src;
  logic rx_meta, rx_sync, rx_prev;
  logic [7:0] rx_rdata, rx_shift;
  rx_state_t rx_state;
  logic [3:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] stat;

  assign wr_acc  = bus.cs && !bus.rw;
  assign rd_acc  = bus.cs && bus.rw;
  assign ctl_wr  = wr_acc && bus.rs == REG_STAT_CTL;
  assign mrst    = ctl_wr && bus.data_in[1:0] == 2'b11;
  assign stat_rd = rd_acc && bus.rs == REG_STAT_CTL;
  assign data_rd = rd_acc && bus.rs == REG_DATA;
  assign tick    = cnt == '0;
  assign div_ext = 16'(div);

`ifdef ACIA_FIFO_UART_LOOPBACK_EN
  logic loop_q;
  assign loop_en = loop_q;
  assign rx_src  = loop_q ? tx_q : rx;
  assign tx      = loop_q ? 1'b1 : tx_q;
`else
  assign loop_en = 1'b0;
  assign rx_src  = rx;
  assign tx      = tx_q;
`endif

  // merge divisor byte writes so the counter can reload at once
  always_comb begin
    div_nxt = div;
    div_wr  = 1'b0;
    unique case (1'b1)
      wr_acc && bus.rs == REG_DIV_LO: begin
        div_nxt[7:0] = bus.data_in;
        div_wr = 1'b1;
      end
      wr_acc && bus.rs == REG_DIV_HI: begin
        div_nxt[DIV_WIDTH-1:8] = bus.data_in[DIV_WIDTH-9:0];
        div_wr = 1'b1;
      end
      default: ;
    endcase
  end

  // divisor register and down-counter; tick every div+1 clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= DEFAULT_DIV;
      cnt <= DEFAULT_DIV;
    end else begin
      div <= div_nxt;
      if (div_wr)    cnt <= div_nxt;
      else if (tick) cnt <= div;
      else           cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  assign tx_pop = !mrst &&
    (tx_state == TX_IDLE ||
     (tx_state == TX_STOP && tick && tx_cnt == LAST));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .clr(mrst),
    .push(wr_acc && bus.rs == REG_DATA), .pop(tx_pop),
    .wdata(bus.data_in), .rdata(tx_rdata),
    .full(tx_full), .empty(tx_empty)
  );

  // transmit framing: start, 8 data LSB first, stop, 16 ticks each
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_q     <= 1'b1;
    end else if (mrst) begin
      tx_state <= TX_IDLE;
      tx_q     <= 1'b1;
    end else begin
      if (tick) tx_cnt <= tx_cnt + 4'd1;
      unique case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_state <= TX_START;
          tx_shift <= tx_rdata;
          tx_cnt   <= '0;
          tx_q     <= 1'b0;
        end
        TX_START: if (tick && tx_cnt == LAST) begin
          tx_state <= TX_DATA;
          tx_bit   <= '0;
          tx_q     <= tx_shift[0];
        end
        TX_DATA: if (tick && tx_cnt == LAST) begin
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            tx_q     <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_q     <= tx_shift[1];
          end
        end
        TX_STOP: if (tick && tx_cnt == LAST) begin
          if (!tx_empty) begin
            tx_state <= TX_START;
            tx_shift <= tx_rdata;
            tx_q     <= 1'b0;
          end else begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // two-flop synchroniser plus one delayed copy for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_push = !mrst && rx_state == RX_STOP &&
                   tick && rx_cnt == LAST;
  assign rx_pop  = data_rd;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .clr(mrst),
    .push(rx_push), .pop(rx_pop),
    .wdata(rx_shift), .rdata(rx_rdata),
    .full(rx_full), .empty(rx_empty)
  );

  // receive framing: mid-bit sampling after a half-bit start check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (mrst) begin
      rx_state <= RX_IDLE;
    end else begin
      if (tick) rx_cnt <= rx_cnt + 4'd1;
      unique case (rx_state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (tick && rx_cnt == HALF) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (tick && rx_cnt == LAST) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end
        RX_STOP: if (tick && rx_cnt == LAST)
          rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // control bits, sticky flags and registered interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxie  <= 1'b0;
      txie  <= 1'b0;
      fe    <= 1'b0;
      ovrn  <= 1'b0;
      irq_q <= 1'b0;
    end else if (mrst) begin
      rxie  <= 1'b0;
      txie  <= 1'b0;
      fe    <= 1'b0;
      ovrn  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctl_wr) begin
        rxie <= bus.data_in[BIT_RXIE];
        txie <= bus.data_in[BIT_TXIE];
      end
      if (stat_rd) fe <= 1'b0;
      if (rx_push && !rx_sync) fe <= 1'b1;
      if (data_rd) ovrn <= 1'b0;
      if (rx_push && rx_full) ovrn <= 1'b1;
      irq_q <= (rxie && !rx_empty) || (txie && tx_empty) ||
               (rxie && ovrn);
    end
  end

`ifdef ACIA_FIFO_UART_LOOPBACK_EN
  // loopback select lives with the control bits but is kept apart
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         loop_q <= 1'b0;
    else if (mrst)   loop_q <= 1'b0;
    else if (ctl_wr) loop_q <= bus.data_in[BIT_LOOP];
  end
`endif

  assign bus.irq = irq_q;

  // read mux: status, RX head, divisor bytes
  always_comb begin
    stat = 8'h00;
    stat[BIT_RDRF] = !rx_empty;
    stat[BIT_TDRE] = !tx_full;
    stat[BIT_FE]   = fe;
    stat[BIT_OVRN] = ovrn;
    stat[BIT_LOOP] = loop_en;
    stat[BIT_IRQ]  = irq_q;
    unique case (bus.rs)
      REG_STAT_CTL: bus.data_out = stat;
      REG_DATA:     bus.data_out = rx_empty ? 8'h00 : rx_rdata;
      REG_DIV_LO:   bus.data_out = div_ext[7:0];
      default:      bus.data_out = div_ext[15:8];
    endcase
  end
endmodule

// File: tb/tb_acia_fifo_uart.sv
// tb_acia_fifo_uart: directed bench for acia_fifo_uart covering
// TX/RX framing, baud, FIFO limits, flags, irq and master reset.
module tb_acia_fifo_uart;
  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  acia_fifo_uart_if bus();

  acia_fifo_uart dut (
    .clk(clk), .rst(rst), .bus(bus), .rx(rx), .tx(tx)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1;
    bus.rw = 1'b0;
    bus.rs = a;
    bus.data_in = d;
    step();
    bus.cs = 1'b0;
    bus.rw = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    bus.rs = a;
    #2;
    d = bus.data_out;
    step();
    bus.cs = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a,
                        input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(tag, 32'(v), 32'(exp));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
    rx = stop;
    step(16);
    rx = 1'b1;
  endtask

  task automatic wait_fall(input int limit, output bit seen);
    logic p;
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      p = tx;
      step();
      if (p && !tx) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic tx_decode(output logic [7:0] b, output logic ok);
    bit   seen;
    logic st;
    logic sp;
    b  = 8'h00;
    ok = 1'b0;
    wait_fall(400, seen);
    if (!seen) return;
    step(8);
    st = tx;
    for (int i = 0; i < 8; i++) begin
      step(16);
      b[i] = tx;
    end
    step(16);
    sp = tx;
    ok = !st && sp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] b;
    logic       ok;
    bit         seen;
    int         errs;
    int         n;

    bus.cs = 1'b0;
    bus.rw = 1'b1;
    bus.rs = 2'd0;
    bus.data_in = 8'h00;
    rx  = 1'b1;
    rst = 1'b1;
    step(3);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_irq", 32'(bus.irq), 0);
    rst = 1'b0;
    step(2);
    chk_rd("rst_stat", 2'd0, 8'h02);
    chk_rd("rst_div_lo", 2'd2, 8'h1A);
    chk_rd("rst_div_hi", 2'd3, 8'h00);

    // 0x55 at div=0: 16 clk per bit, 160 clk per frame
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    wr(2'd1, 8'h55);
    n = 0;
    while (tx && n < 20) begin
      step();
      n++;
    end
    chk("t1_start", 32'(tx), 0);
    frame = {1'b1, 8'h55, 1'b0};
    errs = 0;
    for (int j = 0; j < 160; j++) begin
      if (tx !== frame[j/16]) errs++;
      step();
    end
    chk("t1_frame_errs", errs, 0);
    chk("t1_idle", 32'(tx), 1);

    // div=3: a data bit lasts 16 ticks of 4 clk
    wr(2'd2, 8'h03);
    wr(2'd1, 8'h01);
    wait_fall(100, seen);
    chk("t2_start", 32'(seen), 1);
    n = 0;
    while (!tx && n < 200) begin
      step();
      n++;
    end
    n = 0;
    while (tx && n < 200) begin
      step();
      n++;
    end
    chk("t2_bit_period", n, 64);
    step(600);
    chk("t2_idle", 32'(tx), 1);

    // stall TX; first byte moves to the shifter, then 16 fill the FIFO
    wr(2'd2, 8'hFF);
    wr(2'd3, 8'hFF);
    wr(2'd1, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      wr(2'd1, 8'(8'h30 + i));
      if (i == 14) chk_rd("t2_tdre_15", 2'd0, 8'h02);
      if (i == 15) chk_rd("t2_tdre_16", 2'd0, 8'h00);
    end
    wr(2'd1, 8'hEE);
    chk_rd("t2_full", 2'd0, 8'h00);
    chk("t2_hold", 32'(tx), 0);
    wr(2'd3, 8'h00);
    wr(2'd2, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tx_decode(b, ok);
      chk("t2_tx_byte", 32'(b), 32'(8'(8'h30 + i)));
      chk("t2_tx_fmt", 32'(ok), 1);
    end
    wait_fall(300, seen);
    chk("t2_drop", 32'(seen), 0);

    // RX frame, then glitch rejection
    send_rx(8'hA3, 1'b1);
    chk_rd("t3_rdrf", 2'd0, 8'h03);
    chk_rd("t3_data", 2'd1, 8'hA3);
    chk_rd("t3_empty", 2'd0, 8'h02);
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    chk_rd("t3_glitch", 2'd0, 8'h02);
    chk_rd("t3_empty_rd", 2'd1, 8'h00);

    // framing error
    send_rx(8'h5A, 1'b0);
    rx = 1'b1;
    step(4);
    chk_rd("t4_fe", 2'd0, 8'h13);
    chk_rd("t4_fe_clr", 2'd0, 8'h03);
    chk_rd("t4_data", 2'd1, 8'h5A);

    // overrun with RX irq enabled
    wr(2'd0, 8'h80);
    step(2);
    chk("t5_irq_idle", 32'(bus.irq), 0);
    for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1);
    step(4);
    chk_rd("t5_ovrn", 2'd0, 8'hA3);
    chk("t5_irq", 32'(bus.irq), 1);
    chk_rd("t5_first", 2'd1, 8'h40);
    chk_rd("t5_ovrn_clr", 2'd0, 8'h83);
    chk("t5_irq_hold", 32'(bus.irq), 1);
    for (int i = 1; i < 16; i++)
      chk_rd("t5_drain", 2'd1, 8'(8'h40 + i));
    step();
    chk("t5_irq_off", 32'(bus.irq), 0);
    chk_rd("t5_empty", 2'd0, 8'h02);

    // master reset in the middle of a frame
    wr(2'd0, 8'h20);
    step(2);
    chk("t6_txirq", 32'(bus.irq), 1);
    wr(2'd1, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd1, 8'h00);
    step(20);
    chk("t6_busy", 32'(tx), 0);
    chk("t6_irq_busy", 32'(bus.irq), 0);
    wr(2'd0, 8'h03);
    chk("t6_mrst_tx", 32'(tx), 1);
    chk_rd("t6_stat", 2'd0, 8'h02);
    chk_rd("t6_div_kept", 2'd2, 8'h00);
    wait_fall(200, seen);
    chk("t6_quiet", 32'(seen), 0);
    chk("t6_irq_cleared", 32'(bus.irq), 0);

`ifdef ACIA_FIFO_UART_LOOPBACK_EN
    wr(2'd0, 8'h40);
    chk_rd("lb_ctl", 2'd0, 8'h42);
    wr(2'd1, 8'h3C);
    step(20);
    chk("lb_tx_held", 32'(tx), 1);
    step(200);
    chk_rd("lb_data", 2'd1, 8'h3C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
